// File: rtl/sprite_pkg.sv
// Shared sprite constants and helpers used by the renderers and the sprite ROM arbiter.
package sprite_pkg;

  localparam int SPRITE_ID_PLAYER = 0;
  localparam int SPRITE_ID_BROOM  = 1;
  localparam int SPRITE_ID_SNITCH = 2;
  localparam int SPRITE_ID_SPELL  = 3;

  localparam int SPRITE_ADDR_W = 14;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_best;
  int w_dist;

  // Each candidate's distance from the pointer; the closest active requester wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = j - int'(i_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if ((|(i_req & (NUM_REQ'(1) << j))) && (w_dist < w_best)) begin
        w_best = w_dist;
        o_gnt  = NUM_REQ'(1) << j;
        o_idx  = IDX_W'(j);
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among NUM_REQ renderers with round-robin grant and tagged responses.
// Optional build macro SPRITE_ARB_PRIO0_EN: requester 0 (player) always wins when requesting.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = SPRITE_ADDR_W,
  parameter int DATA_W      = 1,
  parameter int ROM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_q,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int LAST  = ROM_LATENCY;

  logic [IDX_W-1:0]           r_ptr;
  logic [ADDR_W-1:0]          r_rom_addr;
  logic [LAST:0]              r_vld;
  logic [LAST:0][IDX_W-1:0]   r_id;
  logic [DATA_W-1:0]          r_rsp_data;

  logic [NUM_REQ-1:0]         w_rr_gnt;
  logic [IDX_W-1:0]           w_rr_idx;
  logic                       w_rr_any;
  logic [NUM_REQ-1:0]         w_gnt;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_adv;
  logic                       w_any;
  logic [ADDR_W-1:0]          w_addr;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .i_req(req),
    .i_ptr(r_ptr),
    .o_gnt(w_rr_gnt),
    .o_idx(w_rr_idx),
    .o_any(w_rr_any)
  );

`ifdef SPRITE_ARB_PRIO0_EN
  // Player override does not move the pointer, so the others keep their rotation order.
  always_comb begin
    w_gnt = w_rr_gnt;
    w_idx = w_rr_idx;
    w_adv = w_rr_any;
    if (req[0]) begin
      w_gnt = NUM_REQ'(1);
      w_idx = '0;
      w_adv = 1'b0;
    end
  end
`else
  assign w_gnt = w_rr_gnt;
  assign w_idx = w_rr_idx;
  assign w_adv = w_rr_any;
`endif

  assign gnt    = reset ? '0 : w_gnt;
  assign w_any  = |gnt;
  assign w_addr = ADDR_W'(req_addr >> (w_idx * ADDR_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_adv) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr <= '0;
    end else if (w_any) begin
      r_rom_addr <= w_addr;
    end
  end

  // Tag pipe tracks which requester owns each ROM read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld      <= '0;
      r_id       <= '0;
      r_rsp_data <= '0;
    end else begin
      r_vld      <= {r_vld[LAST-1:0], w_any};
      r_id       <= {r_id[LAST-1:0], w_idx};
      r_rsp_data <= rom_q;
    end
  end

  assign rom_addr  = r_rom_addr;
  // Masked so a response already at the output is dropped in the reset cycle itself.
  assign rsp_valid = r_vld[LAST] & ~reset;
  assign rsp_id    = r_id[LAST];
  assign rsp_data  = r_rsp_data;

endmodule
